// File: rtl/blur_stream_out_if.sv
// Valid/ready output stream carrying one tagged beat of PIXCNT pixels.
//
// Signals:
//   m_data  - DWIDTH*PIXCNT-bit beat, pixel 0 in the LSBs
//   m_valid - a beat is presented
//   m_ready - the sink accepts the beat presented this cycle
//   m_sof   - first beat of a frame
//   m_eol   - last beat of a row
//   m_eof   - last beat of a frame
//
// Modports: master (the stage driving the stream), slave (the sink).
interface blur_stream_out_if #(
    parameter int DWIDTH = 10,
    parameter int PIXCNT = 8
);
    logic [DWIDTH*PIXCNT-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_sof;
    logic                     m_eol;
    logic                     m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/blur_stream_out.sv
// Output stage behind the blur filter. The filter pushes beats with no
// backpressure; each beat is tagged with sof/eol/eof from row/column
// position counters, buffered in a first-word-fall-through FIFO and
// presented on a valid/ready master stream. A beat arriving at a full FIFO
// is dropped and flags overflow; beats outside a frame and unexpected or
// empty new_frame pulses flag sync_err.
//
// Ports:
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   rowSize, colSize   - frame geometry, sampled on new_frame
//   new_frame          - single-cycle start-of-frame pulse
//   data_in, data_vld  - push-only input beat and its qualifier
//   m                  - tagged valid/ready output stream (master)
//   fifo_level         - current FIFO occupancy
//   overflow           - sticky: a beat was dropped on a full FIFO
//   sync_err           - sticky: framing error
//   frame_done         - one-cycle pulse after the eof beat handshakes
module blur_stream_out #(
    parameter int DWIDTH     = 10,
    parameter int PIXCNT     = 8,
    parameter int ROWS       = 2048,
    parameter int COLS       = 2448,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [$clog2(ROWS)-1:0]       rowSize,
    input  logic [$clog2(COLS)-1:0]       colSize,
    input  logic                          new_frame,
    input  logic [DWIDTH*PIXCNT-1:0]      data_in,
    input  logic                          data_vld,
    blur_stream_out_if.master             m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          sync_err,
    output logic                          frame_done
);
    localparam int LOG2PIX = $clog2(PIXCNT);
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int BW      = CW - LOG2PIX;
    localparam int DW      = DWIDTH * PIXCNT;
    localparam int EW      = DW + 3;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bpr_q, bpr_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [BW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          overflow_q, overflow_d;
    logic          syncErr_q, syncErr_d;
    logic          frameDone_q, frameDone_d;
    logic [LW-1:0] wrPtr_q, wrPtr_d;
    logic [LW-1:0] rdPtr_q, rdPtr_d;

    logic [EW-1:0] mem [FIFO_DEPTH];

    logic [BW-1:0] newBpr;
    logic          startFrame;
    logic          badFrame;
    logic          inFrame;
    logic          beat;
    logic [BW-1:0] curBpr;
    logic [RW-1:0] curRows;
    logic [BW-1:0] curCol;
    logic [RW-1:0] curRow;
    logic          tagSof;
    logic          tagEol;
    logic          tagEof;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          flagClear;
    logic          errSet;
    logic [EW-1:0] head;

    // The shift consumes every colSize bit, so the ignored low bits simply
    // fall off rather than being left dangling.
    assign newBpr = BW'(colSize >> LOG2PIX);

    // A frame is only accepted with non-zero geometry. A beat arriving in the
    // same cycle as an accepted new_frame belongs to the new frame, so the
    // tag and counter logic below looks at the "effective" sizes/positions,
    // which already reflect the restart.
    always_comb begin
        startFrame = new_frame && (newBpr != '0) && (rowSize != '0);
        badFrame   = new_frame && !startFrame;
        inFrame    = ((state_q == ACTIVE) && !badFrame) || startFrame;
        beat       = data_vld && inFrame;

        curBpr  = startFrame ? newBpr  : bpr_q;
        curRows = startFrame ? rowSize : rows_q;
        curCol  = startFrame ? '0      : col_q;
        curRow  = startFrame ? '0      : row_q;

        tagSof = (curCol == '0) && (curRow == '0);
        tagEol = (curCol == curBpr - BW'(1));
        tagEof = tagEol && (curRow == curRows - RW'(1));
    end

    // FIFO occupancy comes from the pointer difference; the extra pointer bit
    // separates full from empty. Pushing into a full FIFO is allowed when the
    // head leaves on the same edge, which keeps full-rate streaming.
    always_comb begin
        level = wrPtr_q - rdPtr_q;
        empty = (level == '0);
        full  = (level == LW'(FIFO_DEPTH));
        pop   = !empty && m.m_ready;
        push  = beat && (!full || pop);
        head  = mem[rdPtr_q[AW-1:0]];
    end

    // Next-state for the frame FSM, position counters, sticky flags and FIFO
    // pointers. Counters advance on every in-frame beat even when the FIFO
    // drops it, so tagging stays aligned with the incoming frame.
    always_comb begin
        state_d     = state_q;
        bpr_d       = bpr_q;
        rows_d      = rows_q;
        col_d       = col_q;
        row_d       = row_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;

        if (startFrame) begin
            state_d = ACTIVE;
            bpr_d   = newBpr;
            rows_d  = rowSize;
            col_d   = '0;
            row_d   = '0;
        end else if (badFrame) begin
            state_d = IDLE;
        end

        if (beat) begin
            if (tagEol) begin
                col_d = '0;
                row_d = tagEof ? '0 : curRow + RW'(1);
            end else begin
                col_d = curCol + BW'(1);
            end
            if (tagEof) begin
                state_d = IDLE;
            end
        end

        // Only a frame accepted from IDLE clears the sticky flags; a set
        // event in the same cycle still wins.
        flagClear  = startFrame && (state_q == IDLE);
        errSet     = (data_vld && !inFrame) || badFrame
                     || (new_frame && (state_q == ACTIVE));
        syncErr_d  = (syncErr_q && !flagClear) || errSet;
        overflow_d = (overflow_q && !flagClear) || (beat && full && !pop);

        if (push) begin
            wrPtr_d = wrPtr_q + LW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + LW'(1);
        end

        frameDone_d = pop && head[DW+2];
    end

    // All control state resets asynchronously; clearing the pointers
    // discards any queued beats at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            bpr_q       <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            overflow_q  <= 1'b0;
            syncErr_q   <= 1'b0;
            frameDone_q <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            state_q     <= state_d;
            bpr_q       <= bpr_d;
            rows_q      <= rows_d;
            col_q       <= col_d;
            row_q       <= row_d;
            overflow_q  <= overflow_d;
            syncErr_q   <= syncErr_d;
            frameDone_q <= frameDone_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the write
    // pointer has moved past it.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wrPtr_q[AW-1:0]] <= {tagEof, tagEol, tagSof, data_in};
        end
    end

    // Data and tags are gated by valid so nothing stale leaks out of an
    // empty FIFO or during reset.
    assign m.m_valid  = !empty;
    assign m.m_data   = empty ? '0 : head[DW-1:0];
    assign m.m_sof    = !empty && head[DW];
    assign m.m_eol    = !empty && head[DW+1];
    assign m.m_eof    = !empty && head[DW+2];
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign sync_err   = syncErr_q;
    assign frame_done = frameDone_q;
endmodule
